// File: rtl/bin2bcd_converter.sv
// Sequential double-dabble binary-to-packed-BCD converter, one input bit per cycle.
// Optional macro BCD_OVERFLOW_SATURATE_EN: a latched overflow flag forces bcd_o to all nines.
module bin2bcd_converter #(
   parameter int WIDTH  = 20,
   parameter int DIGITS = 7
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      binary_i,
   input  logic                  overflow_i,
   output logic                  ready_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  overflow_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WIDTH-1:0]  shift_q;
   logic [BW-1:0]     acc_q;
   logic [BW-1:0]     acc_adj;
   logic [BW-1:0]     acc_shift;
   logic [CW-1:0]     cnt_q;
   logic              ovf_lat_q;
   logic [BW-1:0]     bcd_q;
   logic              ovf_q;
   logic              accept;
   logic              finish;

   assign accept = (state == IDLE) && start_i;
   // The shift that takes the counter from 1 to 0 is the last one.
   assign finish = (state == OP) && (cnt_q == CW'(1));

   // Add-3 per digit from the pre-shift value; digits never carry into each other.
   always_comb begin
      acc_adj = acc_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (acc_q[4*d +: 4] >= 4'd5) begin
            acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
         end
      end
      acc_shift = {acc_adj[BW-2:0], shift_q[WIDTH-1]};
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_i) state_nxt = OP;
         OP:   if (cnt_q == CW'(1)) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready_o = (state == IDLE);
      done_o  = (state == DONE);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         shift_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_lat_q <= 1'b0;
      end else if (accept) begin
         shift_q   <= binary_i;
         acc_q     <= '0;
         cnt_q     <= CW'(WIDTH);
         ovf_lat_q <= overflow_i;
      end else if (state == OP) begin
         shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
         acc_q     <= acc_shift;
         cnt_q     <= cnt_q - CW'(1);
      end
   end

   // Result registers update only when a conversion completes and hold otherwise.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         bcd_q <= '0;
         ovf_q <= 1'b0;
      end else if (finish) begin
`ifdef BCD_OVERFLOW_SATURATE_EN
         if (ovf_lat_q) begin
            bcd_q <= {DIGITS{4'h9}};
         end else begin
            bcd_q <= acc_shift;
         end
`else
         bcd_q <= acc_shift;
`endif
         ovf_q <= ovf_lat_q;
      end
   end

   assign bcd_o      = bcd_q;
   assign overflow_o = ovf_q;

endmodule

// File: doc/bin2bcd_converter.md
# bin2bcd_converter

Sequential double-dabble converter that turns the 20-bit binary result of the Fibonacci generator into packed BCD for the seven-segment display stage. It sits directly downstream of the generator: `binary_i` and `overflow_i` connect to the generator's `fibonacci_o` and `overflow_o`, and `start_i` is driven by the generator's `done_o`. The block processes one bit per cycle and holds its result until the next conversion completes.

## Interface
- `WIDTH`, 20, binary input width.
- `DIGITS`, 7, number of BCD output digits; must be ≥ ceil(WIDTH·log10 2). Seven digits cover 1,048,575.
- `clk_i`  in  1  system clock; all state changes on the rising edge.
- `reset_i`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  conversion request; sampled only in IDLE.
- `binary_i`  in  WIDTH  unsigned value to convert; captured on an accepted start.
- `overflow_i`  in  1  upstream overflow flag; captured with `binary_i`.
- `ready_o`  out  1  high in IDLE.
- `done_o`  out  1  one-cycle pulse when `bcd_o` is updated.
- `bcd_o`  out  4·DIGITS  packed BCD; digit 0 is in bits [3:0].
- `overflow_o`  out  1  captured overflow flag for the current `bcd_o`.

## Operation
- **States:**
  - IDLE: `ready_o`=1. On `start_i`=1, load the shift register with `binary_i`, clear the BCD accumulator, set the counter to WIDTH, latch `overflow_i`, and go to OP.
  - OP: the per-cycle step is described below. When the counter reaches 0 after the WIDTH-th shift, go to DONE.
  - DONE: `done_o`=1 for this cycle only, then go to IDLE unconditionally.
- **OP step:** each cycle, every accumulator digit ≥ 5 gets +3, computed from the pre-shift value. Then {accumulator, binary shift register} shifts left by 1 and the counter decrements.
- **Counter width:** $clog2(WIDTH+1). Digit adders are 4-bit and never carry between digits.
- **Output registers:** `bcd_o` and `overflow_o` are loaded only on the OP→DONE transition. They hold their value through IDLE and through any following conversion until the next DONE.
- **Start outside IDLE:** `start_i` in OP or DONE is ignored. It is neither queued nor does it restart the conversion.
- **Held start:** `start_i` held high across DONE→IDLE starts a new conversion on the first IDLE cycle.
- **Zero input:** `binary_i`=0 still takes the full WIDTH cycles and produces `bcd_o`=0.

## Timing
- **Reset values:** state=IDLE, `ready_o`=1, `done_o`=0, `bcd_o`=0, `overflow_o`=0, internal registers 0.
- **Reset behaviour:** reset takes effect immediately and asynchronously, and release is synchronous to `clk_i`. Reset asserted mid-conversion aborts it; no `done_o` is produced for the aborted conversion.
- **Latency:** `start_i` accepted at edge N gives OP for edges N+1 … N+WIDTH. DONE is entered at edge N+WIDTH, so `done_o` is high in the cycle after edge N+WIDTH. With the default WIDTH this is 21 cycles from the start edge to the `done_o` edge.
- **Output validity:** `bcd_o` is valid in the same cycle as `done_o`.
- **Throughput:** one conversion per WIDTH+2 cycles.
- **Combinational paths:** `ready_o` and `done_o` are decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `BCD_OVERFLOW_SATURATE_EN`.
- **Defined:** if the latched overflow flag is 1, DONE loads `bcd_o` with all digits 9 (0x9999999 for DIGITS=7) and sets `overflow_o`=1. Cycle timing is unchanged because the shift still runs its WIDTH cycles.
- **Undefined:** `bcd_o` is always the true conversion of the captured `binary_i`, and `overflow_o` mirrors the latched flag.

## Test plan
- Reset low, then release → `ready_o`=1, `bcd_o`=0, `done_o`=0. Reset low mid-OP (edge N+7) → IDLE immediately, no `done_o`, `bcd_o` keeps its reset value 0.
- `binary_i`=832040 (fib(30)), start pulse → `done_o` exactly 21 cycles after the start edge, `bcd_o`=0x0832040, `overflow_o`=0.
- `binary_i`=1048575 → `bcd_o`=0x1048575. `binary_i`=0 → `bcd_o`=0x0000000 after the full 21 cycles.
- Start 832040, then pulse `start_i` with `binary_i`=5 at edges N+3 and N+20 → both ignored, single `done_o`, `bcd_o`=0x0832040.
- `overflow_i`=1, `binary_i`=12345:
  - with `BCD_OVERFLOW_SATURATE_EN` → `bcd_o`=0x9999999, `overflow_o`=1;
  - without it → `bcd_o`=0x0012345, `overflow_o`=1.
- `start_i` held high for 50 cycles with `binary_i`=89 → back-to-back `done_o` pulses 22 cycles apart, each with `bcd_o`=0x0000089.
